// File: rtl/fabric_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : fabric_frame_loader
// Description : Bitstream-to-frame loader. Hunts for a sync word, decodes a
//               column-window header, assembles NumRows 32-bit words per frame
//               onto FrameData_o and pulses one FrameStrobe_o bit per frame.
//               Optional macro FABRIC_CONFIG_CRC_EN adds a CRC-16/CCITT check
//               of header and data against a trailer word.
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_frame_loader #(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumColumns      = 11,
    parameter int          NumRows         = 16,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [31:0]                            bitstream_data_i,
    input  logic                                   bitstream_valid_i,
    output logic                                   bitstream_ready_o,
    output logic                                   busy_o,
    output logic                                   configured_o,
    output logic                                   error_o,
    output logic [FrameBitsPerRow*NumRows-1:0]     FrameData_o,
    output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe_o
);

    localparam int FRAME_W  = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int ROW_W    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int STROBE_W = MaxFramesPerCol * NumColumns;
    localparam int IDX_W    = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
    localparam int DATA_W   = FrameBitsPerRow * NumRows;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(MaxFramesPerCol - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NumRows - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_STROBE = 3'd3,
`ifdef FABRIC_CONFIG_CRC_EN
        ST_CHECK  = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          column;
    logic [8:0]          last_col;
    logic [FRAME_W-1:0]  frame;
    logic [ROW_W-1:0]    row;
    logic [DATA_W-1:0]   frame_data;
    logic [STROBE_W-1:0] strobe;
    logic [IDX_W-1:0]    strobe_idx;
    logic                busy;
    logic                configured;
    logic                err;

    logic                ready;
    logic                accept;
    logic                is_sync;
    logic [7:0]          hdr_fc;
    logic [7:0]          hdr_cc;
    logic [8:0]          hdr_end;
    logic [8:0]          hdr_last;
    logic                hdr_bad;
    logic                last_strobe;

    // Ready is only withheld during the single strobe cycle.
    assign ready       = (state != ST_STROBE);
    assign accept      = bitstream_valid_i && ready;
    assign is_sync     = (bitstream_data_i == SyncWord);

    // Header fields; the window end is compared at 9 bits so fc+cc cannot wrap.
    assign hdr_fc      = bitstream_data_i[7:0];
    assign hdr_cc      = bitstream_data_i[15:8];
    assign hdr_end     = {1'b0, hdr_fc} + {1'b0, hdr_cc};
    assign hdr_last    = hdr_end - 9'd1;
    assign hdr_bad     = (hdr_cc == 8'd0) || (hdr_end > 9'(NumColumns));

    assign last_strobe = (frame == LAST_FRAME) && ({1'b0, column} == last_col);
    assign strobe_idx  = IDX_W'(column) * IDX_W'(MaxFramesPerCol) + IDX_W'(frame);

`ifdef FABRIC_CONFIG_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [31:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && is_sync) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    state_next = hdr_bad ? ST_ERROR : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && (row == LAST_ROW)) begin
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
`ifdef FABRIC_CONFIG_CRC_EN
                state_next = last_strobe ? ST_CHECK : ST_DATA;
`else
                state_next = last_strobe ? ST_DONE : ST_DATA;
`endif
            end
`ifdef FABRIC_CONFIG_CRC_EN
            ST_CHECK: begin
                if (accept) begin
                    state_next = (bitstream_data_i[15:0] == crc) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Position counters, frame assembly and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            column     <= '0;
            last_col   <= '0;
            frame      <= '0;
            row        <= '0;
            frame_data <= '0;
            busy       <= 1'b0;
            configured <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == ST_HEADER && accept && !hdr_bad) begin
                column   <= hdr_fc;
                last_col <= hdr_last;
                frame    <= '0;
                row      <= '0;
            end
            if (state == ST_DATA && accept) begin
                frame_data[int'(row)*FrameBitsPerRow +: FrameBitsPerRow] <= bitstream_data_i;
                row <= row + 1'b1;
            end
            if (state == ST_STROBE) begin
                row <= '0;
                if (frame == LAST_FRAME) begin
                    frame  <= '0;
                    column <= column + 8'd1;
                end else begin
                    frame <= frame + 1'b1;
                end
            end
            // Status flags follow entry into HEADER, DONE and ERROR.
            if (state_next == ST_HEADER && state != ST_HEADER) begin
                busy       <= 1'b1;
                configured <= 1'b0;
                err        <= 1'b0;
            end
            if (state_next == ST_DONE && state != ST_DONE) begin
                busy       <= 1'b0;
                configured <= 1'b1;
            end
            if (state_next == ST_ERROR && state != ST_ERROR) begin
                busy       <= 1'b0;
                configured <= 1'b0;
                err        <= 1'b1;
            end
        end
    end

`ifdef FABRIC_CONFIG_CRC_EN
    // Running CRC over the header and every data word of the current load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc <= 16'hFFFF;
        end else if (accept) begin
            if ((state == ST_IDLE || state == ST_DONE || state == ST_ERROR) && is_sync) begin
                crc <= 16'hFFFF;
            end else if (state == ST_HEADER || state == ST_DATA) begin
                crc <= crc16_word(crc, bitstream_data_i);
            end
        end
    end
`endif

    // One-hot strobe decoded from the current column/frame while in STROBE.
    always_comb begin
        strobe = '0;
        if (state == ST_STROBE) begin
            strobe = {{(STROBE_W-1){1'b0}}, 1'b1} << strobe_idx;
        end
    end

    assign bitstream_ready_o = ready;
    assign busy_o            = busy;
    assign configured_o      = configured;
    assign error_o           = err;
    assign FrameData_o       = frame_data;
    assign FrameStrobe_o     = strobe;

endmodule
`default_nettype wire

// File: tb/tb_fabric_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fabric_frame_loader
// Description : Self-checking bench for fabric_frame_loader. A queue-based
//               model lists the strobes and frame contents each load must
//               produce; a monitor compares every observed strobe against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_frame_loader;

    localparam int          FB   = 32;
    localparam int          MF   = 20;
    localparam int          NC   = 11;
    localparam int          NR   = 16;
    localparam int          DW   = FB * NR;
    localparam int          SW   = MF * NC;
    localparam int          CW   = 512;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [31:0]   data  = '0;
    logic          ready;
    logic          busy;
    logic          configured;
    logic          err;
    logic [DW-1:0] fdata;
    logic [SW-1:0] strobe;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_seen = 0;

    int            exp_idx[$];
    logic [DW-1:0] exp_dat[$];

    always #5 clk = ~clk;

    fabric_frame_loader #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .NumColumns      (NC),
        .NumRows         (NR),
        .SyncWord        (SYNC)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .bitstream_data_i  (data),
        .bitstream_valid_i (valid),
        .bitstream_ready_o (ready),
        .busy_o            (busy),
        .configured_o      (configured),
        .error_o           (err),
        .FrameData_o       (fdata),
        .FrameStrobe_o     (strobe)
    );

    task automatic check_value(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] crc_in, input logic [31:0] w);
        logic [15:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            c = (c[15] ^ w[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Every strobe must match the next expected frame from the model.
    always @(negedge clk) begin
        int idx;
        if (rst_n && strobe != '0) begin
            strobe_seen++;
            check_value("strobe_onehot", $countones(strobe), 1);
            check_value("ready_in_strobe", ready, 0);
            if (exp_idx.size() == 0) begin
                check_value("unexpected_strobe", strobe, 0);
            end else begin
                idx = exp_idx.pop_front();
                check_value("strobe_bit", strobe, CW'(1) << idx);
                check_value("frame_data", fdata, exp_dat.pop_front());
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_value({tag, "_ready"}, ready, 1);
        check_value({tag, "_busy"}, busy, 0);
        check_value({tag, "_configured"}, configured, 0);
        check_value({tag, "_error"}, err, 0);
        check_value({tag, "_data"}, fdata, 0);
        check_value({tag, "_strobe"}, strobe, 0);
    endtask

    // Present one word and hold it until it is accepted; called at posedge+1.
    task automatic send_word(input logic [31:0] w, input int gap_pct);
        int   guard;
        logic rdy;
        if (gap_pct > 0) begin
            while ($urandom_range(99, 0) < gap_pct) begin
                valid = 1'b0;
                data  = $urandom;
                @(posedge clk); #1;
            end
        end
        valid = 1'b1;
        data  = w;
        guard = 0;
        forever begin
            rdy = ready;
            @(posedge clk); #1;
            if (rdy) break;
            guard++;
            if (guard > 50) begin
                check_value("send_timeout", 0, 1);
                break;
            end
        end
        valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] fc, input logic [7:0] cc, input bit idx_data,
                            input int gap_pct, input bit bad_trailer);
        logic [31:0]   hdr;
        logic [DW-1:0] fr;
        logic [15:0]   crc;
        int            base_seen;
        int            k;
        bit            ok;
        ok = (cc != 8'd0) && (int'(fc) + int'(cc) <= NC);
        send_word(SYNC, gap_pct);
        check_value("busy_after_sync", busy, 1);
        check_value("flags_clear_after_sync", {configured, err}, 0);
        hdr       = {16'($urandom), cc, fc};
        crc       = crc_upd(16'hFFFF, hdr);
        base_seen = strobe_seen;
        send_word(hdr, gap_pct);
        if (!ok) begin
            check_value("bad_hdr_error", err, 1);
            check_value("bad_hdr_busy", busy, 0);
            check_value("bad_hdr_configured", configured, 0);
            repeat (3) @(posedge clk);
            #1;
            check_value("bad_hdr_strobes", strobe_seen - base_seen, 0);
            return;
        end
        fr = '0;
        k  = 0;
        for (int c = int'(fc); c < int'(fc) + int'(cc); c++) begin
            for (int f = 0; f < MF; f++) begin
                for (int r = 0; r < NR; r++) begin
                    fr[r*FB +: FB] = idx_data ? 32'(k * NR + r) : $urandom;
                end
                exp_idx.push_back(c * MF + f);
                exp_dat.push_back(fr);
                for (int r = 0; r < NR; r++) begin
                    crc = crc_upd(crc, fr[r*FB +: FB]);
                    send_word(fr[r*FB +: FB], gap_pct);
                end
                k++;
            end
        end
        check_value("configured_in_last_strobe", configured, 0);
`ifdef FABRIC_CONFIG_CRC_EN
        send_word({16'($urandom), crc ^ {15'd0, bad_trailer}}, gap_pct);
        check_value("configured_after_trailer", configured, !bad_trailer);
        check_value("error_after_trailer", err, bad_trailer);
        check_value("busy_after_trailer", busy, 0);
`else
        @(posedge clk); #1;
        check_value("configured_after_load", configured, 1);
        check_value("busy_after_load", busy, 0);
        check_value("error_after_load", err, 0);
`endif
        check_value("strobes_left", exp_idx.size(), 0);
        check_value("strobe_count", strobe_seen - base_seen, int'(cc) * MF);
        check_value("data_hold", fdata, fr);
    endtask

    // Reset asserted during a strobe cycle must clear everything at once.
    task automatic reset_mid_frame();
        send_word(SYNC, 0);
        send_word({16'h0, 8'd1, 8'd2}, 0);
        for (int r = 0; r < NR; r++) begin
            send_word($urandom, 0);
        end
        check_value("strobe_before_reset", |strobe, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_idx.delete();
        exp_dat.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("after_mid_reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("after_reset");

        // Garbage words before sync are ignored.
        for (int i = 0; i < 3; i++) begin
            g = $urandom;
            if (g == SYNC) g = g ^ 32'd1;
            send_word(g, 0);
            check_value("garbage_busy", busy, 0);
        end
        check_value("garbage_strobes", strobe_seen, 0);

        run_load(8'd0, 8'd11, 1'b1, 0, 1'b0);   // full load, index data
        run_load(8'd4, 8'd2, 1'b0, 0, 1'b0);    // partial load, bits 80..119
        run_load(8'd10, 8'd2, 1'b0, 0, 1'b0);   // window overruns columns
        run_load(8'd3, 8'd0, 1'b0, 0, 1'b0);    // zero column count
        run_load(8'd1, 8'd1, 1'b0, 0, 1'b0);    // recovery clears error
        run_load(8'd0, 8'd11, 1'b0, 30, 1'b0);  // random valid gaps
`ifdef FABRIC_CONFIG_CRC_EN
        run_load(8'd3, 8'd1, 1'b0, 0, 1'b1);    // corrupted trailer
        run_load(8'd5, 8'd1, 1'b0, 10, 1'b0);   // correct trailer
`endif
        reset_mid_frame();
        run_load(8'd9, 8'd2, 1'b0, 0, 1'b0);    // clean load after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
